// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the counter width rule.
package bsa_pkg;

  // Sequencer states; encodings are fixed so that state dumps read the same
  // across builds.
  typedef enum logic [1:0] {
    BSA_IDLE  = 2'b00,
    BSA_SHIFT = 2'b01,
    BSA_DONE  = 2'b10
  } bsa_state_e;

  // Bit counter width for a given operand width; the counter only ever
  // reaches width-1.
  function automatic int bsa_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Request/result bus of the bit-serial adder sequencer.
// Optional feature macro: BSA_SUB_EN adds the 'sub' request bit.
interface bit_serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef BSA_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operands, watches status and result.
  modport master (
    output start, a, b, cin,
`ifdef BSA_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  // Sequencer side.
  modport slave (
    input  start, a, b, cin,
`ifdef BSA_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/dff_ar.sv
// Single D flip-flop with asynchronous active-high reset; holds the
// running carry of the bit-serial adder.
module dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Carry storage, cleared immediately on reset.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder sequencer: captures two operands and a carry-in on start,
// adds one bit per clock LSB first, assembles the sum in a shift register
// and pulses done for one cycle. The carry lives in a dff_ar instance.
// Optional feature macro: BSA_SUB_EN (adds subtract via the 'sub' bus bit).
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  bit_serial_adder_ctrl_if.slave bus
);

  localparam int                 BSA_CNT_W = bsa_cnt_w(WIDTH);
  localparam logic [BSA_CNT_W-1:0] CNT_LAST  = BSA_CNT_W'(WIDTH - 1);

  bsa_state_e           state_q, state_d;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [WIDTH-1:0]     sum_r;
  logic                 cout_r;
  logic [BSA_CNT_W-1:0] cnt_q;

  logic                 load;
  logic                 shift;
  logic                 last;
  logic                 carry_q, carry_d;
  logic                 sum_bit;
  logic                 carry_maj;
  logic [WIDTH-1:0]     b_load;
  logic                 carry_load;

  // Operand/carry values taken on the accepting edge.
`ifdef BSA_SUB_EN
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  // One full-adder slice on the current LSBs.
  assign sum_bit   = a_r[0] ^ b_r[0] ^ carry_q;
  assign carry_maj = (a_r[0] & b_r[0]) | (a_r[0] & carry_q) | (b_r[0] & carry_q);

  // Next-state decode plus load/shift/last strobes for the datapath.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    last    = 1'b0;
    case (state_q)
      BSA_IDLE, BSA_DONE: begin
        if (bus.start) begin
          state_d = BSA_SHIFT;
          load    = 1'b1;
        end else begin
          state_d = BSA_IDLE;
        end
      end
      BSA_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = BSA_DONE;
          last    = 1'b1;
        end
      end
      default: state_d = BSA_IDLE;
    endcase
  end

  // State register; start during SHIFT has no effect because SHIFT ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BSA_IDLE;
    else     state_q <= state_d;
  end

  // Carry: seeded on accept, updated by the majority term while shifting.
  always_comb begin
    carry_d = carry_q;
    if (load)       carry_d = carry_load;
    else if (shift) carry_d = carry_maj;
  end

  dff_ar u_carry (
    .clk (clk),
    .rst (rst),
    .d   (carry_d),
    .q   (carry_q)
  );

  // Operand shifters, bit counter, sum assembly and final carry capture.
  // sum/cout are untouched by the accept edge; they change once shifting starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      cnt_q  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (load) begin
      a_r   <= bus.a;
      b_r   <= b_load;
      cnt_q <= '0;
    end else if (shift) begin
      a_r   <= {1'b0, a_r[WIDTH-1:1]};
      b_r   <= {1'b0, b_r[WIDTH-1:1]};
      sum_r <= {sum_bit, sum_r[WIDTH-1:1]};
      // Wrap to zero on the last bit so the counter never passes WIDTH-1.
      cnt_q <= last ? '0 : cnt_q + BSA_CNT_W'(1);
      if (last) cout_r <= carry_maj;
    end
  end

  assign bus.busy = (state_q == BSA_SHIFT);
  assign bus.done = (state_q == BSA_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule
